// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline-stage definitions: the skid-register state encoding, the
// default NOP bubble used by every stage instance (IF/ID, ID/EX, EX/MEM, MEM/WB)
// and a helper that maps a state to its held-entry count.
package pipe_skid_reg_pkg;

  // Control state of a pipeline stage register.
  typedef enum logic [1:0] {
    PSR_EMPTY = 2'd0,  // no entry held, stage outputs a bubble
    PSR_FULL  = 2'd1,  // main entry valid
    PSR_SKID  = 2'd2   // main and skid entries both valid, upstream stalled
  } psr_state_e;

  // Width of the widest stage payload (pc4 concatenated with inst).
  localparam int unsigned PSR_NOP_WIDTH = 64;

  // All-zero payload, which every stage shows while it holds no valid entry.
  localparam logic [PSR_NOP_WIDTH-1:0] PSR_NOP_BUBBLE = '0;

  // Number of entries held in a given state.
  function automatic logic [1:0] psr_occupancy(input psr_state_e state);
    logic [1:0] occ;
    occ = 2'd0;
    case (state)
      PSR_EMPTY: occ = 2'd0;
      PSR_FULL:  occ = 2'd1;
      PSR_SKID:  occ = 2'd2;
      default:   occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage : pipe_skid_reg_pkg

// File: rtl/pipe_skid_reg_entry.sv
// psr_entry: one WIDTH-bit payload register with a load enable and an
// asynchronous clear to the stage bubble value. Used for the main entry and for
// the optional skid entry of pipe_skid_reg.
module psr_entry
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned      WIDTH  = PSR_NOP_WIDTH,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Payload storage: clear to the bubble on reset, capture d_i when loaded.
  // NOTE: the payload is reset, not left unknown, because an empty stage must
  // drive BUBBLE downstream straight out of reset; non-blocking (<=) keeps every
  // flop sampling the pre-edge values so parallel registers update together.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      data_q <= BUBBLE;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule : psr_entry

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: parametrised pipeline stage register with a valid/ready
// handshake, an optional one-entry skid buffer and a synchronous flush.
// With SKID=1 in_ready comes from a flop, so downstream stall (out_ready) has
// no combinational path to upstream. With SKID=0 the stage is a single entry
// whose in_ready follows out_ready in the same cycle.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned      WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(PSR_NOP_BUBBLE),
  parameter int unsigned      SKID   = 1
) (
  input  logic             clk,
  input  logic             clrn,
  // upstream side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  // downstream side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  // control / status
  input  logic             flush,
  output logic [1:0]       occupancy
);

  psr_state_e       state_q, state_d;
  logic             in_fire, out_fire;
  logic             main_load, skid_load;
  logic [WIDTH-1:0] main_d, main_q;
  logic [WIDTH-1:0] skid_d, skid_q;

  assign out_valid = (state_q != PSR_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next-state and entry-load decode; flush overrides every handshake.
  // NOTE: every output of this block gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_d    = in_data;
    skid_load = 1'b0;
    skid_d    = in_data;

    if (flush) begin
      // Held entries and any simultaneous accept are dropped; a simultaneous
      // out_fire has already been consumed downstream.
      state_d   = PSR_EMPTY;
      main_load = 1'b1;
      main_d    = BUBBLE;
      skid_load = 1'b1;
      skid_d    = BUBBLE;
    end else begin
      case (state_q)
        PSR_EMPTY: begin
          if (in_fire) begin
            state_d   = PSR_FULL;
            main_load = 1'b1;
          end
        end

        PSR_FULL: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            // Only reachable with a skid entry: without one, in_ready implies
            // out_ready whenever the stage is full.
            if (SKID != 0) begin
              state_d   = PSR_SKID;
              skid_load = 1'b1;
            end
          end else if (out_fire) begin
            state_d   = PSR_EMPTY;
            main_load = 1'b1;
            main_d    = BUBBLE;
          end
        end

        PSR_SKID: begin
          // in_ready is low here, so only the downstream side can move.
          if (out_fire) begin
            state_d   = PSR_FULL;
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end

        default: begin
          state_d   = PSR_EMPTY;
          main_load = 1'b1;
          main_d    = BUBBLE;
        end
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= PSR_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Main entry: always drives out_data, holds BUBBLE whenever the stage is empty.
  psr_entry #(
    .WIDTH  (WIDTH),
    .BUBBLE (BUBBLE)
  ) u_main (
    .clk    (clk),
    .clrn   (clrn),
    .load_i (main_load),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;

      // Registered ready: drops one cycle after the first stalled accept.
      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != PSR_SKID);
        end
      end

      assign in_ready = in_ready_q;

      // Skid entry: catches the beat that arrives while downstream is stalled.
      psr_entry #(
        .WIDTH  (WIDTH),
        .BUBBLE (BUBBLE)
      ) u_skid (
        .clk    (clk),
        .clrn   (clrn),
        .load_i (skid_load),
        .d_i    (skid_d),
        .q_o    (skid_q)
      );
    end else begin : g_noskid
      // Single entry: accept when empty or when the held entry leaves this cycle.
      assign in_ready = out_ready | ~out_valid;
      assign skid_q   = BUBBLE;
    end
  endgenerate

  assign out_data  = main_q;
  assign occupancy = psr_occupancy(state_q);

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomised bench for pipe_skid_reg: one instance with a skid
// entry (64-bit payload) and one without (16-bit payload), both using non-zero
// bubble values so a wrong empty-stage value is visible.
module tb_pipe_skid_reg;

  localparam int unsigned WA   = 64;
  localparam logic [63:0] BUBA = 64'hDEAD_BEEF_0000_0000;
  localparam int unsigned WB   = 16;
  localparam logic [15:0] BUBB = 16'hFFFF;

  logic clk = 1'b0;
  logic clrn;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [WA-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occupancy;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [WB-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occupancy;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(WA), .BUBBLE(BUBA), .SKID(1)) dut_a (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .flush     (a_flush),
    .occupancy (a_occupancy)
  );

  pipe_skid_reg #(.WIDTH(WB), .BUBBLE(BUBB), .SKID(0)) dut_b (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .flush     (b_flush),
    .occupancy (b_occupancy)
  );

  // Status words: {out_valid, occupancy, in_ready, out_data}.
  function automatic logic [67:0] st_a();
    return {a_out_valid, a_occupancy, a_in_ready, a_out_data};
  endfunction

  function automatic logic [19:0] st_b();
    return {b_out_valid, b_occupancy, b_in_ready, b_out_data};
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [67:0] exp_a;
    logic [19:0] exp_b;
    clrn = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_flush = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;
    #12;
    exp_a = {1'b0, 2'd0, 1'b1, BUBA};
    exp_b = {1'b0, 2'd0, 1'b1, BUBB};
    vectors++;
    if (st_a() !== exp_a) begin
      miscompares++;
      $display("FAIL reset_a got %h want %h", st_a(), exp_a);
    end
    vectors++;
    if (st_b() !== exp_b) begin
      miscompares++;
      $display("FAIL reset_b got %h want %h", st_b(), exp_b);
    end
    @(negedge clk);
    clrn = 1'b1;
    tick();
    vectors++;
    if (st_a() !== exp_a) begin
      miscompares++;
      $display("FAIL reset_release_a got %h want %h", st_a(), exp_a);
    end
  endtask

  task automatic test_stream();
    logic [67:0] exp_a;
    a_out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 64'(i);
      if (i == 1) begin
        #1;
        exp_a = {1'b0, 2'd0, 1'b1, BUBA};
        vectors++;
        if (st_a() !== exp_a) begin
          miscompares++;
          $display("FAIL stream_latency got %h want %h", st_a(), exp_a);
        end
      end
      tick();
      exp_a = {1'b1, 2'd1, 1'b1, 64'(i)};
      vectors++;
      if (st_a() !== exp_a) begin
        miscompares++;
        $display("FAIL stream_beat%0d got %h want %h", i, st_a(), exp_a);
      end
    end
    a_in_valid = 1'b0;
    tick();
    exp_a = {1'b0, 2'd0, 1'b1, BUBA};
    vectors++;
    if (st_a() !== exp_a) begin
      miscompares++;
      $display("FAIL stream_drain got %h want %h", st_a(), exp_a);
    end
  endtask

  task automatic test_stall_absorb();
    logic [67:0] exp_a;
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 64'hA;
    tick();
    exp_a = {1'b1, 2'd1, 1'b1, 64'hA};
    vectors++;
    if (st_a() !== exp_a) begin
      miscompares++;
      $display("FAIL stall_fill got %h want %h", st_a(), exp_a);
    end
    a_out_ready = 1'b0; a_in_data = 64'hB;
    tick();
    exp_a = {1'b1, 2'd2, 1'b0, 64'hA};
    vectors++;
    if (st_a() !== exp_a) begin
      miscompares++;
      $display("FAIL stall_skid got %h want %h", st_a(), exp_a);
    end
    // Upstream keeps offering while not ready: must not be taken.
    a_in_data = 64'hEE;
    tick();
    vectors++;
    if (st_a() !== exp_a) begin
      miscompares++;
      $display("FAIL stall_hold got %h want %h", st_a(), exp_a);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick();
    exp_a = {1'b1, 2'd1, 1'b1, 64'hB};
    vectors++;
    if (st_a() !== exp_a) begin
      miscompares++;
      $display("FAIL stall_release got %h want %h", st_a(), exp_a);
    end
    tick();
    exp_a = {1'b0, 2'd0, 1'b1, BUBA};
    vectors++;
    if (st_a() !== exp_a) begin
      miscompares++;
      $display("FAIL stall_drain got %h want %h", st_a(), exp_a);
    end
  endtask

  task automatic test_flush();
    logic [67:0] exp_a;
    logic [67:0] empty_a;
    empty_a = {1'b0, 2'd0, 1'b1, BUBA};
    // Build SKIDDED with A in main, B in skid.
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 64'hA;
    tick();
    a_out_ready = 1'b0; a_in_data = 64'hB;
    tick();
    exp_a = {1'b1, 2'd2, 1'b0, 64'hA};
    vectors++;
    if (st_a() !== exp_a) begin
      miscompares++;
      $display("FAIL flush_setup got %h want %h", st_a(), exp_a);
    end
    a_flush = 1'b1; a_in_data = 64'hC;
    tick();
    vectors++;
    if (st_a() !== empty_a) begin
      miscompares++;
      $display("FAIL flush_skidded got %h want %h", st_a(), empty_a);
    end
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (st_a() !== empty_a) begin
        miscompares++;
        $display("FAIL flush_quiet%0d got %h want %h", i, st_a(), empty_a);
      end
    end
    // Flush from FULL while an accept and a consume happen in the same cycle.
    a_in_valid = 1'b1; a_in_data = 64'hD;
    tick();
    a_flush = 1'b1; a_in_data = 64'hE;
    tick();
    vectors++;
    if (st_a() !== empty_a) begin
      miscompares++;
      $display("FAIL flush_full got %h want %h", st_a(), empty_a);
    end
    a_flush = 1'b0; a_in_valid = 1'b0;
    tick();
    vectors++;
    if (st_a() !== empty_a) begin
      miscompares++;
      $display("FAIL flush_dropped got %h want %h", st_a(), empty_a);
    end
    a_in_valid = 1'b1; a_in_data = 64'hF;
    tick();
    exp_a = {1'b1, 2'd1, 1'b1, 64'hF};
    vectors++;
    if (st_a() !== exp_a) begin
      miscompares++;
      $display("FAIL flush_refill got %h want %h", st_a(), exp_a);
    end
    a_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    logic [67:0] exp_a;
    logic [67:0] empty_a;
    empty_a = {1'b0, 2'd0, 1'b1, BUBA};
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 64'h55;
    tick();
    exp_a = {1'b1, 2'd1, 1'b1, 64'h55};
    vectors++;
    if (st_a() !== exp_a) begin
      miscompares++;
      $display("FAIL areset_fill got %h want %h", st_a(), exp_a);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    #2;
    clrn = 1'b0;
    #1;
    vectors++;
    if (st_a() !== empty_a) begin
      miscompares++;
      $display("FAIL areset_immediate got %h want %h", st_a(), empty_a);
    end
    @(negedge clk);
    clrn = 1'b1;
    a_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (st_a() !== empty_a) begin
        miscompares++;
        $display("FAIL areset_idle%0d got %h want %h", i, st_a(), empty_a);
      end
    end
    a_in_valid = 1'b1; a_in_data = 64'h66;
    tick();
    exp_a = {1'b1, 2'd1, 1'b1, 64'h66};
    vectors++;
    if (st_a() !== exp_a) begin
      miscompares++;
      $display("FAIL areset_new got %h want %h", st_a(), exp_a);
    end
    a_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_skid0();
    logic [19:0] exp_b;
    b_in_valid = 1'b1; b_out_ready = 1'b1; b_in_data = 16'h0010;
    #1;
    exp_b = {1'b0, 2'd0, 1'b1, BUBB};
    vectors++;
    if (st_b() !== exp_b) begin
      miscompares++;
      $display("FAIL skid0_empty got %h want %h", st_b(), exp_b);
    end
    tick();
    exp_b = {1'b1, 2'd1, 1'b1, 16'h0010};
    vectors++;
    if (st_b() !== exp_b) begin
      miscompares++;
      $display("FAIL skid0_first got %h want %h", st_b(), exp_b);
    end
    b_out_ready = 1'b0; b_in_data = 16'h0011;
    #1;
    exp_b = {1'b1, 2'd1, 1'b0, 16'h0010};
    vectors++;
    if (st_b() !== exp_b) begin
      miscompares++;
      $display("FAIL skid0_stall_comb got %h want %h", st_b(), exp_b);
    end
    tick();
    vectors++;
    if (st_b() !== exp_b) begin
      miscompares++;
      $display("FAIL skid0_stall_hold got %h want %h", st_b(), exp_b);
    end
    b_out_ready = 1'b1;
    #1;
    exp_b = {1'b1, 2'd1, 1'b1, 16'h0010};
    vectors++;
    if (st_b() !== exp_b) begin
      miscompares++;
      $display("FAIL skid0_release_comb got %h want %h", st_b(), exp_b);
    end
    tick();
    exp_b = {1'b1, 2'd1, 1'b1, 16'h0011};
    vectors++;
    if (st_b() !== exp_b) begin
      miscompares++;
      $display("FAIL skid0_second got %h want %h", st_b(), exp_b);
    end
    b_in_valid = 1'b0;
    tick();
    exp_b = {1'b0, 2'd0, 1'b1, BUBB};
    vectors++;
    if (st_b() !== exp_b) begin
      miscompares++;
      $display("FAIL skid0_drain got %h want %h", st_b(), exp_b);
    end
  endtask

  task automatic test_random();
    logic [WA-1:0] qa[$];
    logic [WB-1:0] qb[$];
    logic [WA-1:0] na;
    logic [WB-1:0] nb;
    logic [WA-1:0] ea;
    logic [WB-1:0] eb;
    logic          a_if, a_of, b_if, b_of;
    na = 64'h1000_0000_0000_0000;
    nb = 16'h0100;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 2) != 0);
      a_flush     = ($urandom_range(0, 63) == 0);
      a_in_data   = na;
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_flush     = ($urandom_range(0, 63) == 0);
      b_in_data   = nb;
      #1;
      a_if = a_in_valid & a_in_ready;
      a_of = a_out_valid & a_out_ready;
      b_if = b_in_valid & b_in_ready;
      b_of = b_out_valid & b_out_ready;

      vectors++;
      if ({a_out_valid, a_occupancy, a_in_ready} !==
          {qa.size() != 0, 2'(qa.size()), qa.size() < 2}) begin
        miscompares++;
        $display("FAIL rand_a_status cyc %0d got v=%b occ=%0d rdy=%b want held=%0d",
                 cyc, a_out_valid, a_occupancy, a_in_ready, qa.size());
      end
      vectors++;
      if ({b_out_valid, b_occupancy, b_in_ready} !==
          {qb.size() != 0, 2'(qb.size()), b_out_ready | (qb.size() == 0)}) begin
        miscompares++;
        $display("FAIL rand_b_status cyc %0d got v=%b occ=%0d rdy=%b want held=%0d",
                 cyc, b_out_valid, b_occupancy, b_in_ready, qb.size());
      end

      ea = (qa.size() != 0) ? qa[0] : BUBA;
      vectors++;
      if (a_out_data !== ea) begin
        miscompares++;
        $display("FAIL rand_a_data cyc %0d got %h want %h", cyc, a_out_data, ea);
      end
      eb = (qb.size() != 0) ? qb[0] : BUBB;
      vectors++;
      if (b_out_data !== eb) begin
        miscompares++;
        $display("FAIL rand_b_data cyc %0d got %h want %h", cyc, b_out_data, eb);
      end

      if (a_of && qa.size() != 0) void'(qa.pop_front());
      if (b_of && qb.size() != 0) void'(qb.pop_front());
      if (a_flush) qa.delete();
      else if (a_if) qa.push_back(a_in_data);
      if (b_flush) qb.delete();
      else if (b_if) qb.push_back(b_in_data);
      if (a_if) na = na + 1'b1;
      if (b_if) nb = nb + 1'b1;
      tick();
    end
    a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_absorb();
    test_flush();
    test_async_reset();
    test_skid0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pipe_skid_reg
